reduce_unit_seq: RTL and testbench
==================================

Name: reduce_unit_seq

Overview:
Parametrised, multi-mode serial reduction unit and successor to the single-mode bit-serial logic unit. It accepts a WIDTH-bit request vector over a valid/ready handshake and scans it CHUNK bits per cycle. It then presents a 1-bit reduction result on a valid/ready output handshake with backpressure. It sits between request arbitration logic and its consumers, where area matters more than latency.

Parameters:
WIDTH, 16, request vector width; WIDTH >= 2
CHUNK, 4, bits consumed per SCAN cycle; 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0 (elaboration-time assertion)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_vec  input  WIDTH  request vector, sampled on accept
mode  input  2  reduction op, sampled on accept: 00 OR, 01 AND, 10 XOR, 11 LEGACY
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
out  output  1  reduction result, valid while out_valid=1
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
busy  output  1  high in SCAN or DONE

Behaviour:
- Clocking and reset: reset rst, asynchronous, active-high; clock clk. All state is in one clocked process.
- Reset values: state=IDLE, in_ready=1, out=0, out_valid=0, busy=0; all internal registers 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1.
  - On in_valid=1: latch req_vec and mode, set chunk index idx=0, initialise accumulators (or_acc=0, orx_acc=0, and_acc=1, xor_acc=0), then go to SCAN.
- SCAN: in_ready=0. Each cycle folds bits [idx*CHUNK +: CHUNK] into the accumulators and increments idx.
  - orx_acc ORs the chunk with bit WIDTH-1 masked off.
  - After folding the chunk with idx == WIDTH/CHUNK-1, register the result into out, set out_valid=1, reset idx to 0, and go to DONE.
- Result by mode:
  - OR = |vec
  - AND = &vec
  - XOR = ^vec
  - LEGACY = (|vec[WIDTH-2:0]) & vec[WIDTH-1]
- idx register width: max(1, $clog2(WIDTH/CHUNK)). idx never wraps past WIDTH/CHUNK-1.
- Latency: out_valid rises exactly WIDTH/CHUNK cycles after the accepting edge.
- DONE: out and out_valid are held stable while out_ready=0 (no data change under backpressure); in_ready=0. When out_valid && out_ready, go to IDLE and clear out_valid. out is cleared to 0 whenever out_valid=0.
- Throughput: with out_ready tied high, one request per WIDTH/CHUNK+2 cycles.
- in_valid outside IDLE is ignored. A request held high across a transaction is accepted again only on the next IDLE cycle, never twice within one transaction.
- Changes to mode or req_vec after accept have no effect on the transaction in flight.
- Reset mid-operation: aborts immediately with no result produced; after release the unit is in IDLE with in_ready=1.

Optional Feature:
REDUCE_POPCOUNT_EN
- Defined: adds output port out_cnt, width $clog2(WIDTH+1), holding the number of set bits in the latched vector.
  - Accumulated per chunk in SCAN (adder tree over CHUNK bits plus running sum).
  - Valid and held under the same out_valid/out_ready rules as out; 0 at reset and whenever out_valid=0.
  - Independent of mode.
- Undefined: port and counting logic absent; all other behaviour identical.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4.
1. Mode OR. Inputs 16'h0000, then 16'h0100 (out_ready=1). Expect out=0, then out=1; out_valid high for exactly 1 cycle, 4 cycles after each accept edge.
2. Mode LEGACY. Inputs 16'h8001, 16'h8000, 16'h7FFF, 16'hFFFF. Expect out = 1, 0, 0, 1.
3. Mode AND with 16'hFFFF then 16'hFFFE, expect 1 then 0. Mode XOR with 16'h0007 then 16'h0003, expect 1 then 0.
4. Backpressure. Mode OR, 16'h0001, out_ready=0 for 5 cycles while in_valid=1 with 16'h0000 and mode AND. Expect out_valid=1, out=1 stable, in_ready=0, no new accept. Raise out_ready: next cycle IDLE, in_ready=1, following edge accepts 16'h0000.
5. in_valid held high with out_ready=1. Expect an accept every 6 cycles, each vector processed once. Repeat with CHUNK=1: out_valid 16 cycles after accept. Repeat with CHUNK=16: out_valid 1 cycle after accept.
6. Assert rst 2 cycles into SCAN. Expect out_valid=0, out=0, busy=0 immediately and in_ready=1 after release. With REDUCE_POPCOUNT_EN defined, 16'hF0F1 gives out_cnt=9 and 16'hFFFF gives out_cnt=16.

Source files
------------

// File: rtl/reduce_unit_seq.sv
// reduce_unit_seq: serial multi-mode reduction unit (OR / AND / XOR / LEGACY).
// The WIDTH-bit request vector is accepted over a valid/ready handshake.
// It is scanned CHUNK bits per cycle. The 1-bit result is presented on a
// valid/ready output handshake that supports backpressure.
// Optional feature macro: REDUCE_POPCOUNT_EN adds out_cnt, the number of set
// bits in the accepted vector, reported alongside out.
module reduce_unit_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           req_vec,
    input  logic [1:0]                 mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef REDUCE_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0] out_cnt,
`endif
    output logic                       busy
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
    // Clears the top bit so the LEGACY operand only sees vec[WIDTH-2:0].
    localparam logic [WIDTH-1:0] NO_MSB = {1'b0, {(WIDTH-1){1'b1}}};

    localparam logic [1:0] MODE_OR  = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("reduce_unit_seq: WIDTH must be >= 2 and a multiple of CHUNK (1 <= CHUNK <= WIDTH)");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   vec_q, vec_d;
    logic [1:0]         mode_q, mode_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               or_q, or_d;
    logic               orx_q, orx_d;
    logic               and_q, and_d;
    logic               xor_q, xor_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;

    // Current chunk and the accumulators with that chunk folded in.
    logic [CHUNK-1:0]   chunk;
    logic [CHUNK-1:0]   chunk_nomsb;
    logic               or_f, orx_f, and_f, xor_f;
    logic               result_f;

`ifdef REDUCE_POPCOUNT_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]   cnt_f;

    // Number of set bits within one chunk.
    function automatic logic [CNT_W-1:0] chunk_pop(input logic [CHUNK-1:0] c);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s = s + CNT_W'(c[i]);
        end
        return s;
    endfunction

    assign out_cnt = out_cnt_q;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;

    // Select the chunk at idx and fold it into each accumulator.
    always_comb begin
        chunk       = CHUNK'(vec_q >> (int'(idx_q) * CHUNK));
        chunk_nomsb = CHUNK'((vec_q & NO_MSB) >> (int'(idx_q) * CHUNK));
        or_f        = or_q  | (|chunk);
        orx_f       = orx_q | (|chunk_nomsb);
        and_f       = and_q & (&chunk);
        xor_f       = xor_q ^ (^chunk);
        case (mode_q)
            MODE_OR:  result_f = or_f;
            MODE_AND: result_f = and_f;
            MODE_XOR: result_f = xor_f;
            default:  result_f = orx_f & vec_q[WIDTH-1];
        endcase
`ifdef REDUCE_POPCOUNT_EN
        cnt_f = cnt_q + chunk_pop(chunk);
`endif
    end

    // Next-state and datapath update for the IDLE/SCAN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        or_d        = or_q;
        orx_d       = orx_q;
        and_d       = and_q;
        xor_d       = xor_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
`ifdef REDUCE_POPCOUNT_EN
        cnt_d       = cnt_q;
        out_cnt_d   = out_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    vec_d   = req_vec;
                    mode_d  = mode;
                    idx_d   = '0;
                    or_d    = 1'b0;
                    orx_d   = 1'b0;
                    and_d   = 1'b1;
                    xor_d   = 1'b0;
`ifdef REDUCE_POPCOUNT_EN
                    cnt_d   = '0;
`endif
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                or_d  = or_f;
                orx_d = orx_f;
                and_d = and_f;
                xor_d = xor_f;
`ifdef REDUCE_POPCOUNT_EN
                cnt_d = cnt_f;
`endif
                if (idx_q == LAST_IDX) begin
                    out_d       = result_f;
                    out_valid_d = 1'b1;
                    idx_d       = '0;
`ifdef REDUCE_POPCOUNT_EN
                    out_cnt_d   = cnt_f;
`endif
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                // Result stays frozen until the consumer takes it.
                if (out_ready) begin
                    out_d       = 1'b0;
                    out_valid_d = 1'b0;
`ifdef REDUCE_POPCOUNT_EN
                    out_cnt_d   = '0;
`endif
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state registers; asynchronous reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            mode_q      <= '0;
            idx_q       <= '0;
            or_q        <= 1'b0;
            orx_q       <= 1'b0;
            and_q       <= 1'b0;
            xor_q       <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef REDUCE_POPCOUNT_EN
            cnt_q       <= '0;
            out_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            or_q        <= or_d;
            orx_q       <= orx_d;
            and_q       <= and_d;
            xor_q       <= xor_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef REDUCE_POPCOUNT_EN
            cnt_q       <= cnt_d;
            out_cnt_q   <= out_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_reduce_unit_seq.sv
// Testbench for reduce_unit_seq: directed vectors, scoreboard-checked results.
`timescale 1ns/1ps
module tb_reduce_unit_seq;

    localparam logic [1:0] M_OR  = 2'b00;
    localparam logic [1:0] M_AND = 2'b01;
    localparam logic [1:0] M_XOR = 2'b10;
    localparam logic [1:0] M_LEG = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_vec;
    logic [1:0]  mode;
    logic        in_valid, in_ready, out, out_valid, out_ready, busy;
    logic        v1, r1, o1, ov1, b1;
    logic        v16, r16, o16, ov16, b16;
`ifdef REDUCE_POPCOUNT_EN
    logic [4:0]  out_cnt, cnt1, cnt16;
`endif

    always #5 clk = ~clk;

    reduce_unit_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .req_vec(req_vec), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef REDUCE_POPCOUNT_EN
        .out_cnt(out_cnt),
`endif
        .busy(busy));

    reduce_unit_seq #(.WIDTH(16), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst(rst), .req_vec(req_vec), .mode(mode),
        .in_valid(v1), .in_ready(r1), .out(o1), .out_valid(ov1),
        .out_ready(1'b1),
`ifdef REDUCE_POPCOUNT_EN
        .out_cnt(cnt1),
`endif
        .busy(b1));

    reduce_unit_seq #(.WIDTH(16), .CHUNK(16)) dut_c16 (
        .clk(clk), .rst(rst), .req_vec(req_vec), .mode(mode),
        .in_valid(v16), .in_ready(r16), .out(o16), .out_valid(ov16),
        .out_ready(1'b1),
`ifdef REDUCE_POPCOUNT_EN
        .out_cnt(cnt16),
`endif
        .busy(b16));

    typedef struct {
        logic o;
        int   cnt;
        int   acc;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = -1;
    logic ov_prev = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard whenever the main unit hands over a result.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
                else                check("latency", cyc - sb[0].acc, 4);
            end
            if (!out_valid) check("out_zero_when_idle", int'(out), 0);
            if (out_valid && out_ready && sb.size() > 0) begin
                me = sb.pop_front();
                check("out", int'(out), int'(me.o));
`ifdef REDUCE_POPCOUNT_EN
                check("out_cnt", int'(out_cnt), me.cnt);
`endif
            end
        end
        ov_prev = out_valid;
    end

    // Offer one request; record the expected result when it will be accepted.
    task automatic send(input logic [15:0] v, input logic [1:0] m, input logic eo,
                        input int ec, input bit hold);
        int   n;
        exp_t e;
        req_vec  = v;
        mode     = m;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e.o   = eo;
        e.cnt = ec;
        e.acc = cyc + 1;
        sb.push_back(e);
        if (hold && last_acc >= 0) check("accept_period", e.acc - last_acc, 6);
        last_acc = e.acc;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Latency of the CHUNK=1 / CHUNK=16 variants, measured from the accept edge.
    task automatic aux_lat(input bit use16, input int exp_l, input string name);
        int   n;
        logic ov;
        req_vec = 16'h0100;
        mode    = M_OR;
        @(negedge clk);
        check({name, "_in_ready"}, int'(use16 ? r16 : r1), 1);
        if (use16) v16 = 1'b1;
        else       v1  = 1'b1;
        @(posedge clk);
        #1;
        v1  = 1'b0;
        v16 = 1'b0;
        n  = 0;
        ov = 1'b0;
        while (!ov && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            ov = use16 ? ov16 : ov1;
        end
        check({name, "_latency"}, n, exp_l);
        check({name, "_out"}, int'(use16 ? o16 : o1), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_vec = '0; mode = M_OR; in_valid = 1'b0; out_ready = 1'b1;
        v1 = 1'b0; v16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out", int'(out), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // OR mode
        send(16'h0000, M_OR, 1'b0, 0, 1'b0);
        send(16'h0100, M_OR, 1'b1, 1, 1'b0);
        // LEGACY mode
        send(16'h8001, M_LEG, 1'b1, 2, 1'b0);
        send(16'h8000, M_LEG, 1'b0, 1, 1'b0);
        send(16'h7FFF, M_LEG, 1'b0, 15, 1'b0);
        send(16'hFFFF, M_LEG, 1'b1, 16, 1'b0);
        // AND and XOR modes
        send(16'hFFFF, M_AND, 1'b1, 16, 1'b0);
        send(16'hFFFE, M_AND, 1'b0, 15, 1'b0);
        send(16'h0007, M_XOR, 1'b1, 3, 1'b0);
        send(16'h0003, M_XOR, 1'b0, 2, 1'b0);
        drain();

        // Backpressure: result frozen, a pending request is not taken
        out_ready = 1'b0;
        send(16'h0001, M_OR, 1'b1, 1, 1'b0);
        in_valid = 1'b1;
        req_vec  = 16'h0000;
        mode     = M_AND;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out", int'(out), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_busy", int'(busy), 0);
        send(16'h0000, M_AND, 1'b0, 0, 1'b0);
        drain();

        // in_valid held high: one accept per 6 cycles, each vector once
        last_acc = -1;
        send(16'h0100, M_OR, 1'b1, 1, 1'b1);
        send(16'h0000, M_OR, 1'b0, 0, 1'b1);
        send(16'h00F0, M_XOR, 1'b0, 4, 1'b1);
        send(16'h0070, M_XOR, 1'b1, 3, 1'b1);
        in_valid = 1'b0;
        drain();

        // Other chunk sizes
        aux_lat(1'b0, 16, "c1");
        aux_lat(1'b1, 1, "c16");

        // Population count vectors
        send(16'hF0F1, M_OR, 1'b1, 9, 1'b0);
        send(16'hFFFF, M_AND, 1'b1, 16, 1'b0);
        drain();

        // Reset two cycles into SCAN aborts with no result
        req_vec  = 16'hFFFF;
        mode     = M_OR;
        in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out", int'(out), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_in_ready", int'(in_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_busy", int'(busy), 0);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
